// File: rtl/pid_sched.sv
// pid_sched - configuration loader and sample scheduler for the pid block.
//
// A serial frame of 4*BITS+DIV_BITS bits (MSB first: sp, kp, ki, kd, rate) is shifted
// in on cfg_data while cfg_en is high. A frame of the correct length is committed when
// cfg_en drops. After a commit, pid_rst is held for two cycles and then periodic pv_stb
// pulses are issued every rate+1 cycles, each capturing pv_raw into pv.
//
// Optional feature: define PID_SCHED_EXTTRIG_EN to add ext_trig. With rate==0 each
// synchronized rising edge of ext_trig then produces one strobe.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_en, cfg_data  serial configuration stream
//   pv_raw            unregistered process value from the pads
//   ext_trig          external sample trigger (PID_SCHED_EXTTRIG_EN only)
//   pid_rst           active-high reset to pid
//   pv_stb, pv        sample strobe and the value captured with it
//   sp, kp, ki, kd    committed configuration
//   running           scheduler is issuing strobes
//   cfg_err           sticky frame-length error
module pid_sched #(
   parameter int unsigned BITS     = 4,
   parameter int unsigned DIV_BITS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_en,
   input  logic            cfg_data,
   input  logic [BITS-1:0] pv_raw,
`ifdef PID_SCHED_EXTTRIG_EN
   input  logic            ext_trig,
`endif
   output logic            pid_rst,
   output logic            pv_stb,
   output logic [BITS-1:0] pv,
   output logic [BITS-1:0] sp,
   output logic [BITS-1:0] kp,
   output logic [BITS-1:0] ki,
   output logic [BITS-1:0] kd,
   output logic            running,
   output logic            cfg_err
);

   localparam int unsigned N     = 4 * BITS + DIV_BITS;
   localparam int unsigned CNT_W = $clog2(N + 2);

   localparam logic [CNT_W-1:0]    CntFull = CNT_W'(N);
   localparam logic [CNT_W-1:0]    CntSat  = CNT_W'(N + 1);
   localparam logic [CNT_W-1:0]    CntOne  = CNT_W'(1);
   localparam logic [DIV_BITS-1:0] DivOne  = DIV_BITS'(1);

   typedef enum logic [1:0] {StUncfg, StLoad, StArm, StRun} state_e;

   state_e              state_q, state_d;
   logic                from_run_q, from_run_d;
   logic                arm_q, arm_d;
   logic [N-1:0]        sr_q, sr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DIV_BITS-1:0] div_q, div_d;
   logic [DIV_BITS-1:0] rate_q, rate_d;
   logic [BITS-1:0]     sp_q, sp_d, kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
   logic [BITS-1:0]     pv_q, pv_d;
   logic                pv_stb_q, pv_stb_d;
   logic                cfg_err_q, cfg_err_d;
   logic                strobing;

`ifdef PID_SCHED_EXTTRIG_EN
   // [0],[1] synchronizer, [2] previous synchronized value for edge detection
   logic [2:0] trig_q;
   logic       trig_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q <= '0;
      end else begin
         trig_q <= {trig_q[1:0], ext_trig};
      end
   end

   assign trig_rise = trig_q[1] & ~trig_q[2];
`endif

   // The old configuration keeps strobing while a new frame is loaded from RUN.
   assign strobing = (state_q == StRun) || ((state_q == StLoad) && from_run_q);

   always_comb begin
      state_d    = state_q;
      from_run_d = from_run_q;
      arm_d      = arm_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      rate_d     = rate_q;
      sp_d       = sp_q;
      kp_d       = kp_q;
      ki_d       = ki_q;
      kd_d       = kd_q;
      cfg_err_d  = cfg_err_q;
      pv_stb_d   = 1'b0;

      // Sample divider; runs ahead of the FSM so a commit on a zero count still strobes.
      if (strobing) begin
`ifdef PID_SCHED_EXTTRIG_EN
         if (rate_q == '0) begin
            pv_stb_d = trig_rise;
         end else
`endif
         if (div_q == '0) begin
            pv_stb_d = 1'b1;
            div_d    = rate_q;
         end else begin
            div_d = div_q - DivOne;
         end
      end

      // Shift in config bits everywhere except ARM; counter saturates at N+1.
      if (cfg_en && (state_q != StArm)) begin
         sr_d  = {sr_q[N-2:0], cfg_data};
         cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + CntOne;
      end

      unique case (state_q)
         StUncfg: begin
            if (cfg_en) begin
               state_d    = StLoad;
               from_run_d = 1'b0;
            end
         end
         StLoad: begin
            if (!cfg_en) begin
               cnt_d = '0;
               if (cnt_q == CntFull) begin
                  sp_d      = sr_q[N-1 -: BITS];
                  kp_d      = sr_q[N-BITS-1 -: BITS];
                  ki_d      = sr_q[N-2*BITS-1 -: BITS];
                  kd_d      = sr_q[N-3*BITS-1 -: BITS];
                  rate_d    = sr_q[DIV_BITS-1:0];
                  cfg_err_d = 1'b0;
                  arm_d     = 1'b0;
                  state_d   = StArm;
               end else begin
                  cfg_err_d = 1'b1;
                  state_d   = from_run_q ? StRun : StUncfg;
               end
            end
         end
         StArm: begin
            div_d = rate_q;
            if (arm_q) begin
               state_d = StRun;
            end else begin
               arm_d = 1'b1;
            end
         end
         StRun: begin
            if (cfg_en) begin
               state_d    = StLoad;
               from_run_d = 1'b1;
            end
         end
         default: state_d = StUncfg;
      endcase

      pv_d = pv_stb_d ? pv_raw : pv_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StUncfg;
         from_run_q <= 1'b0;
         arm_q      <= 1'b0;
         sr_q       <= '0;
         cnt_q      <= '0;
         div_q      <= '0;
         rate_q     <= '0;
         sp_q       <= '0;
         kp_q       <= '0;
         ki_q       <= '0;
         kd_q       <= '0;
         pv_q       <= '0;
         pv_stb_q   <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         from_run_q <= from_run_d;
         arm_q      <= arm_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         rate_q     <= rate_d;
         sp_q       <= sp_d;
         kp_q       <= kp_d;
         ki_q       <= ki_d;
         kd_q       <= kd_d;
         pv_q       <= pv_d;
         pv_stb_q   <= pv_stb_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign pid_rst = ~strobing;
   assign running = strobing;
   assign pv_stb  = pv_stb_q;
   assign pv      = pv_q;
   assign sp      = sp_q;
   assign kp      = kp_q;
   assign ki      = ki_q;
   assign kd      = kd_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pid_sched.sv
// Self-checking bench for pid_sched. Expected strobes (cycle number and pv value) are
// pushed to a scoreboard when stimulus is driven; every cycle the bench pops and compares
// them against pv_stb/pv, and flags any strobe that was not expected.
module tb_pid_sched;

   localparam int BIG = 1 << 30;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       cfg_en   = 1'b0;
   logic       cfg_data = 1'b0;
   logic [3:0] pv_raw   = 4'd0;
`ifdef PID_SCHED_EXTTRIG_EN
   logic       ext_trig = 1'b0;
`endif
   logic       pid_rst, pv_stb, running, cfg_err;
   logic [3:0] pv, sp, kp, ki, kd;

   pid_sched #(
      .BITS     (4),
      .DIV_BITS (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_en   (cfg_en),
      .cfg_data (cfg_data),
      .pv_raw   (pv_raw),
`ifdef PID_SCHED_EXTTRIG_EN
      .ext_trig (ext_trig),
`endif
      .pid_rst  (pid_rst),
      .pv_stb   (pv_stb),
      .pv       (pv),
      .sp       (sp),
      .kp       (kp),
      .ki       (ki),
      .kd       (kd),
      .running  (running),
      .cfg_err  (cfg_err)
   );

   typedef struct {
      int         cyc;
      logic [3:0] pv;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   next_stb = BIG;
   int   period   = 1;
   int   c_ref    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // One clock: compare strobe at the negedge, then advance to just after the posedge.
   task automatic step(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc || pv_stb !== 1'b1 || pv !== e.pv) begin
               errors++;
               $display("FAIL strobe: cyc %0d pv_stb=%b pv=%0d, expected strobe at cyc %0d pv=%0d",
                        cyc, pv_stb, pv, e.cyc, e.pv);
            end
         end else if (pv_stb !== 1'b0) begin
            errors++;
            $display("FAIL unexpected_strobe: cyc %0d pv_stb=%b, expected 0", cyc, pv_stb);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_to(input int last);
      while (cyc <= last) step(1);
   endtask

   // Reference model of the divider cadence: queue every strobe up to cycle 'last'.
   task automatic push_until(input int last);
      exp_t e;
      while (next_stb <= last) begin
         e.cyc = next_stb;
         e.pv  = pv_raw;
         sb.push_back(e);
         next_stb += period;
      end
   endtask

   task automatic send_bits(input logic [23:0] frame, input int n, input bit finish);
      for (int i = n - 1; i >= 0; i--) begin
         cfg_en   = 1'b1;
         cfg_data = frame[i];
         step(1);
      end
      cfg_en   = 1'b0;
      cfg_data = 1'b0;
      if (finish) step(1);
   endtask

   task automatic check_cfg(input string name, input logic [15:0] exp_cfg,
                            input logic exp_err);
      checks++;
      if ({sp, kp, ki, kd} !== exp_cfg || cfg_err !== exp_err) begin
         errors++;
         $display("FAIL %s: cfg=%h cfg_err=%b, expected cfg=%h cfg_err=%b",
                  name, {sp, kp, ki, kd}, cfg_err, exp_cfg, exp_err);
      end
   endtask

   task automatic check_ctl(input string name, input logic exp_rst, input logic exp_run);
      checks++;
      if (pid_rst !== exp_rst || running !== exp_run) begin
         errors++;
         $display("FAIL %s: pid_rst=%b running=%b, expected pid_rst=%b running=%b",
                  name, pid_rst, running, exp_rst, exp_run);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(3);
      checks++;
      if ({pid_rst, pv_stb, running, cfg_err, pv, sp, kp, ki, kd} !== {1'b1, 23'd0}) begin
         errors++;
         $display("FAIL reset_values: got %b, expected %b",
                  {pid_rst, pv_stb, running, cfg_err, pv, sp, kp, ki, kd}, {1'b1, 23'd0});
      end
      rst_n = 1'b1;
      step(10);
      checks++;
      if ({pid_rst, pv_stb, running, cfg_err, pv, sp, kp, ki, kd} !== {1'b1, 23'd0}) begin
         errors++;
         $display("FAIL idle_uncfg: got %b, expected %b",
                  {pid_rst, pv_stb, running, cfg_err, pv, sp, kp, ki, kd}, {1'b1, 23'd0});
      end
   endtask

   task automatic test_config();
      pv_raw = 4'd9;
      send_bits(24'h532104, 24, 1'b1);
      c_ref = cyc;
      check_cfg("commit", 16'h5321, 1'b0);
      check_ctl("arm_cycle1", 1'b1, 1'b0);
      step(1);
      check_ctl("arm_cycle2", 1'b1, 1'b0);
      step(1);
      check_ctl("run_entry", 1'b0, 1'b1);
      next_stb = c_ref + 7;
      period   = 5;
      push_until(c_ref + 12);
      run_to(c_ref + 12);
   endtask

   task automatic test_pv_hold();
      run_to(c_ref + 13);
      push_until(c_ref + 14);
      pv_raw = 4'd7;
      checks++;
      if (pv !== 4'd9) begin
         errors++;
         $display("FAIL pv_hold_a: pv=%0d, expected 9", pv);
      end
      push_until(c_ref + 17);
      run_to(c_ref + 15);
      checks++;
      if (pv !== 4'd9) begin
         errors++;
         $display("FAIL pv_hold_b: pv=%0d, expected 9", pv);
      end
      run_to(c_ref + 17);
      checks++;
      if (pv !== 4'd7) begin
         errors++;
         $display("FAIL pv_new: pv=%0d, expected 7", pv);
      end
   endtask

   task automatic test_bad_frame();
      int t;
      t = cyc;
      push_until(t + 23);
      send_bits(24'h7FFFFF, 23, 1'b1);
      check_cfg("short_frame", 16'h5321, 1'b1);
      check_ctl("short_frame_run", 1'b0, 1'b1);
      t = cyc;
      push_until(t + 10);
      run_to(t + 10);
   endtask

   task automatic test_reconfig();
      int t;
      t = cyc;
      push_until(t + 25);
      send_bits(24'h643202, 24, 1'b1);
      c_ref = cyc;
      check_cfg("reconfig", 16'h6432, 1'b0);
      check_ctl("rearm1", 1'b1, 1'b0);
      step(1);
      check_ctl("rearm2", 1'b1, 1'b0);
      step(1);
      check_ctl("rerun", 1'b0, 1'b1);
      next_stb = c_ref + 5;
      period   = 3;
      push_until(c_ref + 12);
      run_to(c_ref + 12);
   endtask

   task automatic test_reset_mid_frame();
      int t;
      t = cyc;
      push_until(t + 11);
      send_bits(24'h000532, 12, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pid_rst, running, pv_stb, sp, kp, ki, kd} !== {1'b1, 18'd0}) begin
         errors++;
         $display("FAIL reset_mid_frame: got %b, expected %b",
                  {pid_rst, running, pv_stb, sp, kp, ki, kd}, {1'b1, 18'd0});
      end
      next_stb = BIG;
      step(2);
      rst_n = 1'b1;
      step(2);
      send_bits(24'h532104, 24, 1'b1);
      c_ref = cyc;
      check_cfg("commit_after_reset", 16'h5321, 1'b0);
      step(2);
      check_ctl("run_after_reset", 1'b0, 1'b1);
      next_stb = c_ref + 7;
      period   = 5;
      push_until(c_ref + 17);
      run_to(c_ref + 17);
   endtask

`ifdef PID_SCHED_EXTTRIG_EN
   task automatic test_ext_trig();
      int   t;
      exp_t e;
      t = cyc;
      push_until(t + 25);
      send_bits(24'h532100, 24, 1'b1);
      c_ref    = cyc;
      next_stb = BIG;
      check_cfg("commit_ext", 16'h5321, 1'b0);
      step(6);
      for (int p = 0; p < 3; p++) begin
         pv_raw   = 4'(p + 3);
         ext_trig = 1'b1;
         e.cyc    = cyc + 3;
         e.pv     = pv_raw;
         sb.push_back(e);
         step(2);
         ext_trig = 1'b0;
         step(6);
      end
   endtask
`else
   task automatic test_rate0();
      int   t;
      exp_t e;
      t = cyc;
      push_until(t + 25);
      send_bits(24'h532100, 24, 1'b1);
      c_ref    = cyc;
      next_stb = BIG;
      check_cfg("commit_rate0", 16'h5321, 1'b0);
      for (int i = 0; i < 12; i++) begin
         pv_raw = 4'(i);
         if (cyc + 1 >= c_ref + 3) begin
            e.cyc = cyc + 1;
            e.pv  = pv_raw;
            sb.push_back(e);
         end
         step(1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_config();
      test_pv_hold();
      test_bad_frame();
      test_reconfig();
      test_reset_mid_frame();
`ifdef PID_SCHED_EXTTRIG_EN
      test_ext_trig();
`else
      test_rate0();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
